if_fetcher: RTL and testbench
=============================

IF_FETCHER -- requirements
Module: if_fetcher

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` input 1, rising-edge clock; `rst` input 1, active-high reset sampled only on `clk` rising edge.
REQ-002 Port `pc_init` SHALL be a parameter, default 32'h0, giving the fetch PC loaded on reset.
REQ-003 Port `accessor_STALLER_i` SHALL be input, 2 bits, the current bus owner from the RAM arbiter: 2'b00 IF_ACCESS, 2'b01 IF_BLOCK_MEM, 2'b10 MEM_BLOCK_IF.
REQ-004 Port `din_RAM_i` SHALL be input, 8 bits, the RAM read byte for the address driven one cycle earlier.
REQ-005 Port `flush_i` SHALL be input, 1 bit, a redirect request (branch/jump) valid for one cycle.
REQ-006 Port `flush_pc_i` SHALL be input, 32 bits, the redirect target, sampled when `flush_i`=1.
REQ-007 Port `ready_ID_i` SHALL be input, 1 bit, decode accepts the held instruction this cycle.
REQ-008 Port `addr_ARB_o` SHALL be output, 32 bits, the instruction byte address to the arbiter (its IF address input).
REQ-009 Port `FSM_ARB_o` SHALL be output, 4 bits, the fetch-in-progress code to the arbiter; nonzero means IF holds the bus.
REQ-010 Port `inst_ID_o` SHALL be output, 32 bits, the assembled instruction.
REQ-011 Port `pc_ID_o` SHALL be output, 32 bits, the address of `inst_ID_o`.
REQ-012 Port `valid_ID_o` SHALL be output, 1 bit, `inst_ID_o`/`pc_ID_o` valid.

Function
REQ-013 The FSM SHALL have states IDLE=0, S1=1, S2=2, S3=3, S4=4, S5=5, HOLD=6.
REQ-014 IDLE SHALL go to S1 when `accessor_STALLER_i` != MEM_BLOCK_IF, and otherwise stay in IDLE (MEM wins while IF is idle).
REQ-015 S1->S2->S3->S4->S5->HOLD SHALL advance unconditionally, one state per cycle.
REQ-016 `addr_ARB_o` SHALL be pc in IDLE/S1, pc+1 in S2, pc+2 in S3, pc+3 in S4, and pc in S5/HOLD; all additions are 32-bit and wrap modulo 2^32.
REQ-017 `FSM_ARB_o` SHALL equal the state code in S1–S4 and be 4'b0000 in IDLE, S5 and HOLD, so the bus is released as soon as the last address is issued.
REQ-018 Byte capture SHALL take `din_RAM_i` into byte0 at the end of S2, byte1 at the end of S3, byte2 at the end of S4 and byte3 at the end of S5.
REQ-019 Assembly SHALL be little-endian: `inst_ID_o` = {byte3,byte2,byte1,byte0}.
REQ-020 On entering HOLD, `inst_ID_o` SHALL be the assembled word, `pc_ID_o` SHALL be the current pc and `valid_ID_o` SHALL be 1.
REQ-021 In HOLD with `ready_ID_i`=1, the next state SHALL be IDLE, pc SHALL become pc+4 (wrapping) and `valid_ID_o` SHALL become 0.
REQ-022 In HOLD with `ready_ID_i`=0, all outputs SHALL hold unchanged.
REQ-023 The latency SHALL be: from IDLE with the bus free at cycle t, `valid_ID_o`=1 at cycle t+6; back-to-back fetches with `ready_ID_i` tied 1 take 7 cycles per instruction.
REQ-024 `flush_i`=1 in any state SHALL, at the next edge, set state=IDLE, pc=`flush_pc_i` and `valid_ID_o`=0, and SHALL discard partial bytes.
REQ-025 `flush_i` SHALL have priority over the normal transition and over `ready_ID_i` in the same cycle.
REQ-026 The accessor value SHALL be ignored in S1–S5, because the arbiter grants IF whenever `FSM_ARB_o` != 0.

Reset
REQ-027 `rst`=1 at a rising edge SHALL force state=IDLE, pc=`pc_init`, byte0..3=0, `inst_ID_o`=0, `pc_ID_o`=0 and `valid_ID_o`=0, with `addr_ARB_o`=`pc_init` and `FSM_ARB_o`=0 the following cycle.
REQ-028 Reset SHALL have priority over `flush_i`, and mid-fetch reset SHALL abandon the fetch with no valid output.

Verification
REQ-029 Reset then bus free, RAM[0..3]=13,05,A0,00, `ready_ID_i`=1 -> `addr_ARB_o` 0,0,1,2,3; `valid_ID_o` at cycle 6; `inst_ID_o`=32'h00A00513, `pc_ID_o`=0; next fetch at pc 4.
REQ-030 `accessor_STALLER_i`=MEM_BLOCK_IF for 3 cycles while in IDLE -> state stays IDLE, `FSM_ARB_o`=0; S1 entered the cycle after release; valid 3 cycles later than in REQ-029.
REQ-031 `ready_ID_i`=0 for 4 cycles in HOLD -> `valid_ID_o`, `inst_ID_o` and `pc_ID_o` stable; pc advances only on the cycle `ready_ID_i`=1.
REQ-032 `flush_i`=1 with `flush_pc_i`=32'h100 during S3 -> IDLE next cycle, no valid; the next instruction has `pc_ID_o`=32'h100 with bytes from 100..103.
REQ-033 pc=32'hFFFFFFFC fetch accepted -> next pc=0; `rst`=1 during S4 -> all outputs at reset values, `FSM_ARB_o`=0 next cycle.

Source files
------------

// File: rtl/if_fetcher_if.sv
// Fetch-side bus bundle: arbiter handshake, RAM read byte, redirect and decode hand-off.
// The fetcher uses the master modport; the arbiter/RAM/decode side uses the slave modport.
interface if_fetcher_if;
  logic [1:0]  accessor_STALLER_i;
  logic [7:0]  din_RAM_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        ready_ID_i;
  logic [31:0] addr_ARB_o;
  logic [3:0]  FSM_ARB_o;
  logic [31:0] inst_ID_o;
  logic [31:0] pc_ID_o;
  logic        valid_ID_o;

  modport master (
    input  accessor_STALLER_i, din_RAM_i, flush_i, flush_pc_i, ready_ID_i,
    output addr_ARB_o, FSM_ARB_o, inst_ID_o, pc_ID_o, valid_ID_o
  );

  modport slave (
    output accessor_STALLER_i, din_RAM_i, flush_i, flush_pc_i, ready_ID_i,
    input  addr_ARB_o, FSM_ARB_o, inst_ID_o, pc_ID_o, valid_ID_o
  );
endinterface

// File: rtl/if_fetcher.sv
// Instruction fetcher: reads four RAM bytes through the arbiter, assembles a little-endian
// word and holds it for decode until accepted.
//
// state | meaning
// IDLE  | waiting for the arbiter to let IF onto the bus
// S1    | address pc issued
// S2    | address pc+1 issued, byte0 arrives
// S3    | address pc+2 issued, byte1 arrives
// S4    | address pc+3 issued, byte2 arrives
// S5    | bus released, byte3 arrives
// HOLD  | instruction valid, waiting for decode
module if_fetcher #(
  parameter logic [31:0] pc_init = 32'h0
) (
  input  logic      clk,
  input  logic      rst,
  if_fetcher_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    S5   = 3'd5,
    HOLD = 3'd6
  } state_t;

  localparam logic [1:0] MEM_BLOCK_IF = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  byte0_q, byte0_d;
  logic [7:0]  byte1_q, byte1_d;
  logic [7:0]  byte2_q, byte2_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= pc_init;
      byte0_q <= 8'h00;
      byte1_q <= 8'h00;
      byte2_q <= 8'h00;
      inst_q  <= 32'h0;
      pc_id_q <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      byte0_q <= byte0_d;
      byte1_q <= byte1_d;
      byte2_q <= byte2_d;
      inst_q  <= inst_d;
      pc_id_q <= pc_id_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    byte0_d = byte0_q;
    byte1_d = byte1_q;
    byte2_d = byte2_q;
    inst_d  = inst_q;
    pc_id_d = pc_id_q;
    valid_d = valid_q;
    if (bus.flush_i) begin
      // Redirect wins over everything but reset; partial bytes are dropped.
      state_d = IDLE;
      pc_d    = bus.flush_pc_i;
      byte0_d = 8'h00;
      byte1_d = 8'h00;
      byte2_d = 8'h00;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.accessor_STALLER_i != MEM_BLOCK_IF) state_d = S1;
        S1:   state_d = S2;
        S2: begin
          state_d = S3;
          byte0_d = bus.din_RAM_i;
        end
        S3: begin
          state_d = S4;
          byte1_d = bus.din_RAM_i;
        end
        S4: begin
          state_d = S5;
          byte2_d = bus.din_RAM_i;
        end
        S5: begin
          state_d = HOLD;
          inst_d  = {bus.din_RAM_i, byte2_q, byte1_q, byte0_q};
          pc_id_d = pc_q;
          valid_d = 1'b1;
        end
        HOLD: begin
          if (bus.ready_ID_i) begin
            state_d = IDLE;
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.addr_ARB_o = pc_q;
    bus.FSM_ARB_o  = 4'b0000;
    unique case (state_q)
      S1: bus.FSM_ARB_o = 4'd1;
      S2: begin
        bus.addr_ARB_o = pc_q + 32'd1;
        bus.FSM_ARB_o  = 4'd2;
      end
      S3: begin
        bus.addr_ARB_o = pc_q + 32'd2;
        bus.FSM_ARB_o  = 4'd3;
      end
      S4: begin
        bus.addr_ARB_o = pc_q + 32'd3;
        bus.FSM_ARB_o  = 4'd4;
      end
      default: begin
        bus.addr_ARB_o = pc_q;
        bus.FSM_ARB_o  = 4'b0000;
      end
    endcase
  end

  assign bus.inst_ID_o  = inst_q;
  assign bus.pc_ID_o    = pc_id_q;
  assign bus.valid_ID_o = valid_q;

endmodule

// File: tb/tb_if_fetcher.sv
// Directed bench for if_fetcher: byte-wide RAM model with one-cycle read latency
// and hand-computed expected addresses, arbiter codes and assembled words.
module tb_if_fetcher;
  logic clk;
  logic rst;
  logic [31:0] addr_prev;
  int vectors;
  int miscompares;

  if_fetcher_if bus_if ();

  if_fetcher u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: 0..3 hold 13 05 A0 00, every other byte is addr[7:0] + 8'h11.
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'd0:   ram_byte = 8'h13;
      32'd1:   ram_byte = 8'h05;
      32'd2:   ram_byte = 8'hA0;
      32'd3:   ram_byte = 8'h00;
      default: ram_byte = a[7:0] + 8'h11;
    endcase
  endfunction

  always @(posedge clk) addr_prev <= bus_if.addr_ARB_o;
  assign bus_if.din_RAM_i = ram_byte(addr_prev);

  logic [31:0] exp_addr [6];
  logic [3:0]  exp_fsm  [6];

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus_if.accessor_STALLER_i = 2'b00;
    bus_if.flush_i = 1'b0;
    bus_if.flush_pc_i = 32'h0;
    bus_if.ready_ID_i = 1'b1;
    tick(2);
    vectors++;
    if ({bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o, bus_if.FSM_ARB_o, bus_if.addr_ARB_o} !== 101'h0) begin
      miscompares++;
      $display("FAIL reset: valid=%0b inst=%h pc=%h fsm=%h addr=%h, required all zero",
               bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o, bus_if.FSM_ARB_o, bus_if.addr_ARB_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_fetch;
    exp_addr = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    exp_fsm  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (bus_if.addr_ARB_o !== exp_addr[i] || bus_if.FSM_ARB_o !== exp_fsm[i] || bus_if.valid_ID_o !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_seq c%0d: addr=%h fsm=%h valid=%0b, required addr=%h fsm=%h valid=0",
                 i, bus_if.addr_ARB_o, bus_if.FSM_ARB_o, bus_if.valid_ID_o, exp_addr[i], exp_fsm[i]);
      end
      tick(1);
    end
    vectors++;
    if ({bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o} !== {1'b1, 32'h00A00513, 32'h0}) begin
      miscompares++;
      $display("FAIL basic_out: valid=%0b inst=%h pc=%h, required 1 00a00513 00000000",
               bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o);
    end
  endtask

  task automatic test_back_to_back;
    bus_if.ready_ID_i = 1'b1;
    tick(1);
    vectors++;
    if (bus_if.addr_ARB_o !== 32'd4 || bus_if.FSM_ARB_o !== 4'd0 || bus_if.valid_ID_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: addr=%h fsm=%h valid=%0b, required 4 0 0",
               bus_if.addr_ARB_o, bus_if.FSM_ARB_o, bus_if.valid_ID_o);
    end
    tick(5);
    vectors++;
    if (bus_if.valid_ID_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_early: valid=%0b, required 0", bus_if.valid_ID_o);
    end
    tick(1);
    vectors++;
    if ({bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o} !== {1'b1, 32'h18171615, 32'd4}) begin
      miscompares++;
      $display("FAIL b2b_out: valid=%0b inst=%h pc=%h, required 1 18171615 00000004",
               bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o);
    end
  endtask

  task automatic test_mem_block;
    bus_if.accessor_STALLER_i = 2'b10;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus_if.FSM_ARB_o !== 4'd0 || bus_if.addr_ARB_o !== 32'd8) begin
        miscompares++;
        $display("FAIL blocked c%0d: fsm=%h addr=%h, required 0 00000008", i, bus_if.FSM_ARB_o, bus_if.addr_ARB_o);
      end
      tick(1);
    end
    bus_if.accessor_STALLER_i = 2'b00;
    bus_if.ready_ID_i = 1'b0;
    vectors++;
    if (bus_if.FSM_ARB_o !== 4'd0) begin
      miscompares++;
      $display("FAIL release_idle: fsm=%h, required 0", bus_if.FSM_ARB_o);
    end
    tick(1);
    vectors++;
    if (bus_if.FSM_ARB_o !== 4'd1 || bus_if.addr_ARB_o !== 32'd8) begin
      miscompares++;
      $display("FAIL release_s1: fsm=%h addr=%h, required 1 00000008", bus_if.FSM_ARB_o, bus_if.addr_ARB_o);
    end
    tick(4);
    vectors++;
    if (bus_if.valid_ID_o !== 1'b0 || bus_if.FSM_ARB_o !== 4'd0) begin
      miscompares++;
      $display("FAIL blocked_s5: valid=%0b fsm=%h, required 0 0", bus_if.valid_ID_o, bus_if.FSM_ARB_o);
    end
    tick(1);
    vectors++;
    if ({bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o} !== {1'b1, 32'h1C1B1A19, 32'd8}) begin
      miscompares++;
      $display("FAIL blocked_out: valid=%0b inst=%h pc=%h, required 1 1c1b1a19 00000008",
               bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o);
    end
  endtask

  task automatic test_hold_stall;
    bus_if.ready_ID_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      vectors++;
      if ({bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o, bus_if.addr_ARB_o} !==
          {1'b1, 32'h1C1B1A19, 32'd8, 32'd8}) begin
        miscompares++;
        $display("FAIL stall c%0d: valid=%0b inst=%h pc=%h addr=%h, required 1 1c1b1a19 8 8",
                 i, bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o, bus_if.addr_ARB_o);
      end
    end
    bus_if.ready_ID_i = 1'b1;
    tick(1);
    vectors++;
    if (bus_if.addr_ARB_o !== 32'hC || bus_if.valid_ID_o !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_accept: addr=%h valid=%0b, required 0000000c 0", bus_if.addr_ARB_o, bus_if.valid_ID_o);
    end
  endtask

  task automatic test_flush;
    tick(3);
    vectors++;
    if (bus_if.addr_ARB_o !== 32'hE || bus_if.FSM_ARB_o !== 4'd3) begin
      miscompares++;
      $display("FAIL flush_s3: addr=%h fsm=%h, required 0000000e 3", bus_if.addr_ARB_o, bus_if.FSM_ARB_o);
    end
    bus_if.flush_i = 1'b1;
    bus_if.flush_pc_i = 32'h100;
    tick(1);
    bus_if.flush_i = 1'b0;
    vectors++;
    if (bus_if.addr_ARB_o !== 32'h100 || bus_if.FSM_ARB_o !== 4'd0 || bus_if.valid_ID_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle: addr=%h fsm=%h valid=%0b, required 00000100 0 0",
               bus_if.addr_ARB_o, bus_if.FSM_ARB_o, bus_if.valid_ID_o);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      vectors++;
      if (bus_if.valid_ID_o !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_novalid c%0d: valid=%0b, required 0", i, bus_if.valid_ID_o);
      end
    end
    tick(1);
    vectors++;
    if ({bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o} !== {1'b1, 32'h14131211, 32'h100}) begin
      miscompares++;
      $display("FAIL flush_out: valid=%0b inst=%h pc=%h, required 1 14131211 00000100",
               bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o);
    end
    bus_if.flush_i = 1'b1;
    bus_if.flush_pc_i = 32'hFFFFFFFC;
    tick(1);
    bus_if.flush_i = 1'b0;
    vectors++;
    if (bus_if.addr_ARB_o !== 32'hFFFFFFFC || bus_if.valid_ID_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_over_ready: addr=%h valid=%0b, required fffffffc 0", bus_if.addr_ARB_o, bus_if.valid_ID_o);
    end
  endtask

  task automatic test_wrap;
    tick(4);
    vectors++;
    if (bus_if.addr_ARB_o !== 32'hFFFFFFFF || bus_if.FSM_ARB_o !== 4'd4) begin
      miscompares++;
      $display("FAIL wrap_s4: addr=%h fsm=%h, required ffffffff 4", bus_if.addr_ARB_o, bus_if.FSM_ARB_o);
    end
    tick(2);
    vectors++;
    if ({bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o} !== {1'b1, 32'h100F0E0D, 32'hFFFFFFFC}) begin
      miscompares++;
      $display("FAIL wrap_out: valid=%0b inst=%h pc=%h, required 1 100f0e0d fffffffc",
               bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o);
    end
    tick(1);
    vectors++;
    if (bus_if.addr_ARB_o !== 32'h0 || bus_if.valid_ID_o !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_pc: addr=%h valid=%0b, required 00000000 0", bus_if.addr_ARB_o, bus_if.valid_ID_o);
    end
  endtask

  task automatic test_mid_reset;
    tick(4);
    vectors++;
    if (bus_if.FSM_ARB_o !== 4'd4 || bus_if.addr_ARB_o !== 32'd3) begin
      miscompares++;
      $display("FAIL midrst_s4: fsm=%h addr=%h, required 4 00000003", bus_if.FSM_ARB_o, bus_if.addr_ARB_o);
    end
    rst = 1'b1;
    bus_if.flush_i = 1'b1;
    bus_if.flush_pc_i = 32'h200;
    tick(1);
    rst = 1'b0;
    bus_if.flush_i = 1'b0;
    vectors++;
    if ({bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o, bus_if.FSM_ARB_o, bus_if.addr_ARB_o} !== 101'h0) begin
      miscompares++;
      $display("FAIL midrst: valid=%0b inst=%h pc=%h fsm=%h addr=%h, required all zero",
               bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o, bus_if.FSM_ARB_o, bus_if.addr_ARB_o);
    end
    tick(6);
    vectors++;
    if ({bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o} !== {1'b1, 32'h00A00513, 32'h0}) begin
      miscompares++;
      $display("FAIL midrst_refetch: valid=%0b inst=%h pc=%h, required 1 00a00513 00000000",
               bus_if.valid_ID_o, bus_if.inst_ID_o, bus_if.pc_ID_o);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus_if.accessor_STALLER_i = 2'b00;
    bus_if.flush_i = 1'b0;
    bus_if.flush_pc_i = 32'h0;
    bus_if.ready_ID_i = 1'b1;
    test_reset();
    test_basic_fetch();
    test_back_to_back();
    test_mem_block();
    test_hold_stall();
    test_flush();
    test_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
